float_mul_arbiter: RTL
======================

# float_mul_arbiter

- Round-robin arbiter that shares one `float_multiplier` (IEEE-754 single-precision, A*B=>Z, one operation in flight) between up to N_REQ requesters.
- Requesters are ADS1292 filter stages issuing coefficient×sample products.
- Sits between the filter stage controllers and the multiplier.
- Owns both multiplier handshakes (AB_STB/AB_ACK, Z_STB/Z_ACK) and routes each result back to the requester that issued it.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)

Ports:
- i_CLK  in  1  clock
- i_RST  in  1  reset; synchronous, active-high
- i_REQ_A  in  32*N_REQ  operand A per requester; slice k = [32k+31:32k]
- i_REQ_B  in  32*N_REQ  operand B per requester
- i_REQ_STB  in  N_REQ  request valid; held with stable operands until o_REQ_ACK[k]
- o_REQ_ACK  out  N_REQ  one-cycle pulse: operands of requester k captured
- o_RES_Z  out  32  result, shared by all requesters
- o_RES_STB  out  N_REQ  result valid for requester k; held until i_RES_ACK[k]
- i_RES_ACK  in  N_REQ  requester k has taken o_RES_Z
- o_MUL_A, o_MUL_B  out  32  operands to multiplier
- o_MUL_AB_STB  out  1  operands valid to multiplier
- i_MUL_AB_ACK  in  1  multiplier ready for operands
- i_MUL_Z  in  32  multiplier result
- i_MUL_Z_STB  in  1  multiplier result valid
- o_MUL_Z_ACK  out  1  arbiter takes result
- o_BUSY  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT_Z, DELIVER.
- IDLE, any i_REQ_STB high:
  - Grant g = first set bit searching upward (with wrap) from last_grant+1.
  - Latch i_REQ_A/B slice g into o_MUL_A/B and store the one-hot grant.
  - o_REQ_ACK[g] <= 1 for exactly one cycle.
  - Go to ISSUE.
- IDLE, no request: all strobes low; stay.
- ISSUE: o_MUL_AB_STB = 1. On the cycle o_MUL_AB_STB && i_MUL_AB_ACK: drop o_MUL_AB_STB, go to WAIT_Z.
- WAIT_Z: o_MUL_Z_ACK = 1. On the cycle i_MUL_Z_STB && o_MUL_Z_ACK: latch i_MUL_Z into o_RES_Z, drop o_MUL_Z_ACK, go to DELIVER.
- DELIVER: o_RES_STB[g] = 1. On the cycle o_RES_STB[g] && i_RES_ACK[g]: clear o_RES_STB, set last_grant <= g, go to IDLE.
- i_RES_ACK bits of non-granted requesters are ignored.
- Arbitration happens only in IDLE. Requests arriving or dropping in any other state have no effect until the next IDLE.
- The result is passed through unchanged: NaN, Inf, zero and denormal encodings are not inspected.
- Reset (also when asserted mid-operation): state IDLE, last_grant = N_REQ-1 (requester 0 wins first), all outputs 0, o_RES_Z = 0.
  - The multiplier shares i_RST, so no transaction survives a reset.

## Timing
- i_REQ_STB sampled in IDLE at edge t → o_REQ_ACK[g] high during cycle t+1 only. The requester drops STB at edge t+1.
- o_MUL_AB_STB rises in the same cycle as o_REQ_ACK.
- o_RES_STB[g] rises one cycle after the Z handshake edge.
- Back-to-back: a pending request is granted in the first IDLE cycle after the DELIVER handshake, giving 1 idle cycle between operations.
- Fairness: with all N_REQ requesting continuously, grants rotate 0,1,…,N_REQ-1,0. Any requester waits at most N_REQ-1 operations.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- FLOAT_MUL_ARB_CNT_EN defined:
  - Adds port o_OP_CNT out 16.
  - The counter increments on every DELIVER handshake, wraps 0xFFFF→0x0000, and resets to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package float_arb_pkg:
  - FSM state encoding localparams (2-bit).
  - FLOAT_W = 32.
  - OP_CNT_W = 16.
- Sub-module rr_picker (combinational):
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant and its index.
  - Reusable for other shared float units (adder).

## Test plan
- Single request: req0 A=0x40000000, B=0x40400000 → ack0 pulse 1 cycle; o_RES_STB[0] with o_RES_Z=0x40C00000; o_BUSY falls after i_RES_ACK[0].
- All four requesters assert at once with A=B=0x3FC00000 → grants in order 0,1,2,3; each gets 0x40100000; exactly one o_RES_STB bit high at any time.
- Requester 2 holds i_RES_ACK low for 20 cycles → o_RES_STB[2] and o_RES_Z stay stable; no new grant; o_MUL_AB_STB stays low.
- Slow multiplier: i_MUL_AB_ACK delayed 5 cycles and i_MUL_Z_STB delayed 10 cycles → no operand change while o_MUL_AB_STB is high; the correct result is delivered.
- i_RST asserted in WAIT_Z → next cycle all outputs 0, state IDLE; a following req1 is granted before req0 only if req0 is idle; otherwise req0 is granted first.
- With FLOAT_MUL_ARB_CNT_EN: preload 0xFFFE completions, run 3 ops → o_OP_CNT sequence FFFF, 0000, 0001.

Source files
------------

// File: rtl/float_arb_pkg.sv
// Shared types and constants for the float multiplier arbiter and its round-robin picker.
package float_arb_pkg;

  localparam int unsigned FLOAT_W  = 32;
  localparam int unsigned OP_CNT_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_Z  = 2'd2;
  localparam logic [1:0] ST_DELIVER = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = ST_IDLE,
    StIssue   = ST_ISSUE,
    StWaitZ   = ST_WAIT_Z,
    StDeliver = ST_DELIVER
  } arb_state_e;

endpackage

// File: rtl/float_mul_arbiter_if.sv
// Requester and multiplier handshake bundle of float_mul_arbiter.
// slave = the arbiter itself; master = requesters plus multiplier driving it.
interface float_mul_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import float_arb_pkg::*;

  logic [FLOAT_W*N_REQ-1:0] i_REQ_A;
  logic [FLOAT_W*N_REQ-1:0] i_REQ_B;
  logic [N_REQ-1:0]         i_REQ_STB;
  logic [N_REQ-1:0]         o_REQ_ACK;
  logic [FLOAT_W-1:0]       o_RES_Z;
  logic [N_REQ-1:0]         o_RES_STB;
  logic [N_REQ-1:0]         i_RES_ACK;
  logic [FLOAT_W-1:0]       o_MUL_A;
  logic [FLOAT_W-1:0]       o_MUL_B;
  logic                     o_MUL_AB_STB;
  logic                     i_MUL_AB_ACK;
  logic [FLOAT_W-1:0]       i_MUL_Z;
  logic                     i_MUL_Z_STB;
  logic                     o_MUL_Z_ACK;
  logic                     o_BUSY;

  modport master (
    output i_REQ_A, i_REQ_B, i_REQ_STB, i_RES_ACK, i_MUL_AB_ACK, i_MUL_Z, i_MUL_Z_STB,
    input  o_REQ_ACK, o_RES_Z, o_RES_STB, o_MUL_A, o_MUL_B, o_MUL_AB_STB, o_MUL_Z_ACK, o_BUSY
  );

  modport slave (
    input  i_REQ_A, i_REQ_B, i_REQ_STB, i_RES_ACK, i_MUL_AB_ACK, i_MUL_Z, i_MUL_Z_STB,
    output o_REQ_ACK, o_RES_Z, o_RES_STB, o_MUL_A, o_MUL_B, o_MUL_AB_STB, o_MUL_Z_ACK, o_BUSY
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first request above last_i (with wrap) wins.
// Generic over the request count so other shared float units can reuse it.
module rr_picker #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IdxW  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  last_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]  idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = IdxW'((32'(last_i) + i) % N_REQ);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/float_mul_arbiter.sv
// Round-robin sharing of one float_multiplier among N_REQ requesters; results routed back.
// Define FLOAT_MUL_ARB_CNT_EN to add the o_OP_CNT completed-operation counter.
module float_mul_arbiter
  import float_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic                i_CLK,
  input  logic                i_RST,
  float_mul_arbiter_if.slave  bus
`ifdef FLOAT_MUL_ARB_CNT_EN
  ,
  output logic [OP_CNT_W-1:0] o_OP_CNT
`endif
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  arb_state_e         state_q, state_d;
  logic [IdxW-1:0]    last_q, last_d;
  logic [IdxW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   req_ack_q, req_ack_d;
  logic [N_REQ-1:0]   res_stb_q, res_stb_d;
  logic [FLOAT_W-1:0] mul_a_q, mul_a_d;
  logic [FLOAT_W-1:0] mul_b_q, mul_b_d;
  logic [FLOAT_W-1:0] res_z_q, res_z_d;
  logic               ab_stb_q, ab_stb_d;
  logic               z_ack_q, z_ack_d;
  logic               busy_q, busy_d;

  logic [N_REQ-1:0]   pick_gnt;
  logic [IdxW-1:0]    pick_idx;
  logic [FLOAT_W-1:0] sel_a, sel_b;
  logic               deliver_hs;

  rr_picker #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_picker (
    .req_i  (bus.i_REQ_STB),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (pick_gnt[k]) begin
        sel_a = bus.i_REQ_A[k*FLOAT_W +: FLOAT_W];
        sel_b = bus.i_REQ_B[k*FLOAT_W +: FLOAT_W];
      end
    end
  end

  // Only the granted requester's result acknowledge completes delivery.
  assign deliver_hs = (state_q == StDeliver) && |(res_stb_q & bus.i_RES_ACK);

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gidx_d    = gidx_q;
    gnt_d     = gnt_q;
    req_ack_d = '0;
    res_stb_d = res_stb_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    res_z_d   = res_z_q;
    ab_stb_d  = ab_stb_q;
    z_ack_d   = z_ack_q;
    case (state_q)
      StIdle: begin
        if (|bus.i_REQ_STB) begin
          state_d   = StIssue;
          gnt_d     = pick_gnt;
          gidx_d    = pick_idx;
          mul_a_d   = sel_a;
          mul_b_d   = sel_b;
          req_ack_d = pick_gnt;
          ab_stb_d  = 1'b1;
        end
      end
      StIssue: begin
        if (ab_stb_q && bus.i_MUL_AB_ACK) begin
          state_d  = StWaitZ;
          ab_stb_d = 1'b0;
          z_ack_d  = 1'b1;
        end
      end
      StWaitZ: begin
        if (z_ack_q && bus.i_MUL_Z_STB) begin
          state_d   = StDeliver;
          res_z_d   = bus.i_MUL_Z;
          z_ack_d   = 1'b0;
          res_stb_d = gnt_q;
        end
      end
      StDeliver: begin
        if (deliver_hs) begin
          state_d   = StIdle;
          res_stb_d = '0;
          last_d    = gidx_q;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(N_REQ - 1);
      gidx_q    <= '0;
      gnt_q     <= '0;
      req_ack_q <= '0;
      res_stb_q <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      res_z_q   <= '0;
      ab_stb_q  <= 1'b0;
      z_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      req_ack_q <= req_ack_d;
      res_stb_q <= res_stb_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      res_z_q   <= res_z_d;
      ab_stb_q  <= ab_stb_d;
      z_ack_q   <= z_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_REQ_ACK    = req_ack_q;
  assign bus.o_RES_STB    = res_stb_q;
  assign bus.o_RES_Z      = res_z_q;
  assign bus.o_MUL_A      = mul_a_q;
  assign bus.o_MUL_B      = mul_b_q;
  assign bus.o_MUL_AB_STB = ab_stb_q;
  assign bus.o_MUL_Z_ACK  = z_ack_q;
  assign bus.o_BUSY       = busy_q;

`ifdef FLOAT_MUL_ARB_CNT_EN
  logic [OP_CNT_W-1:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q;
    if (deliver_hs) op_cnt_d = op_cnt_q + OP_CNT_W'(1);
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) op_cnt_q <= '0;
    else       op_cnt_q <= op_cnt_d;
  end

  assign o_OP_CNT = op_cnt_q;
`endif

endmodule
